modify_uart_rx: RTL and testbench

UART receiver paired with `modify_Uart_tx`; shares its parameter set and baud arithmetic. It oversamples `rx_pin` with the system clock, recovers 8N1 frames (LSB first) and presents each byte on a valid/ready handshake. It also flags framing errors, overruns and, optionally, parity errors. It sits at the board-facing edge of the serial link, feeding the challenge/response logic.

---
 rtl/modify_uart_pkg.sv | 20 ++
 rtl/uart_bit_sync.sv | 22 ++
 rtl/modify_uart_rx.sv | 175 +++++++++++++++++
 tb/tb_modify_uart_rx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/modify_uart_pkg.sv
// Shared types and baud arithmetic for the modify_uart transmitter/receiver pair.
package modify_uart_pkg;

   localparam int SYNC_STAGES = 2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_state_e;

   // Clocks per bit time; truncation matches the transmitter.
   function automatic int uart_cycle(input int clk_mhz, input int baud);
      return (clk_mhz * 1000000) / baud;
   endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Multi-flop synchronizer for an asynchronous, idle-high serial line; resets to 1.
module uart_bit_sync
   import modify_uart_pkg::*;
#(
   parameter int STAGES = SYNC_STAGES
) (
   input  logic clk,
   input  logic n_reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) ff <= '1;
      else          ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/modify_uart_rx.sv
// 8N1 (or 8E1 with UART_RX_PARITY_EN) UART receiver with valid/ready output,
// framing, overrun and optional parity error pulses.
module modify_uart_rx
   import modify_uart_pkg::*;
#(
   parameter int Challenge_Bit = 8,
   parameter int CLK_FRE       = 16,
   parameter int BAUD_RATE     = 115200
) (
   input  logic                     clk,
   input  logic                     n_reset,
   input  logic                     rx_pin,
   output logic [Challenge_Bit-1:0] rx_data,
   output logic                     rx_data_valid,
   input  logic                     rx_data_ready,
   output logic                     rx_frame_err,
   output logic                     rx_overrun,
   output logic                     rx_parity_err
);

   localparam int CYCLE = uart_cycle(CLK_FRE, BAUD_RATE);
   localparam int CNT_W = $clog2(CYCLE);
   localparam int BIT_W = $clog2(Challenge_Bit);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CYCLE/2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CYCLE - 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(Challenge_Bit - 1);

   logic                     rx_s;
   rx_state_e                state, state_nxt;
   logic [CNT_W-1:0]         cnt;
   logic [BIT_W-1:0]         bit_idx;
   logic [Challenge_Bit-1:0] shift;
   logic                     cnt_clr, shift_en, deliver, frame_err_set, frame_ok;

   uart_bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .n_reset (n_reset),
      .d       (rx_pin),
      .q       (rx_s)
   );

`ifdef UART_RX_PARITY_EN
   logic par_chk, par_bad, bad_q;
   assign par_bad  = par_chk && (rx_s != ^shift);
   assign frame_ok = !bad_q;
`else
   assign frame_ok = 1'b1;
`endif

   always_comb begin
      state_nxt     = state;
      cnt_clr       = 1'b0;
      shift_en      = 1'b0;
      deliver       = 1'b0;
      frame_err_set = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_chk       = 1'b0;
`endif
      case (state)
         IDLE: begin
            cnt_clr = 1'b1;
            if (!rx_s) state_nxt = START;
         end
         START: begin
            if (cnt == HALF_LAST) begin
               cnt_clr   = 1'b1;
               state_nxt = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == FULL_LAST) begin
               cnt_clr  = 1'b1;
               shift_en = 1'b1;
               if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt == FULL_LAST) begin
               cnt_clr   = 1'b1;
               par_chk   = 1'b1;
               state_nxt = STOP;
            end
         end
`endif
         STOP: begin
            if (cnt == FULL_LAST) begin
               cnt_clr = 1'b1;
               if (rx_s) begin
                  deliver   = frame_ok;
                  state_nxt = IDLE;
               end else begin
                  frame_err_set = 1'b1;
                  state_nxt     = BREAK;
               end
            end
         end
         BREAK: begin
            // Hold off until the line returns high so a stuck-low line cannot retrigger.
            cnt_clr = 1'b1;
            if (rx_s) state_nxt = IDLE;
         end
         default: begin
            cnt_clr   = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) state <= IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         cnt <= cnt_clr ? '0 : cnt + 1'b1;
         if (shift_en) begin
            shift   <= {rx_s, shift[Challenge_Bit-1:1]};
            bit_idx <= bit_idx + 1'b1;
         end else if (state == IDLE) begin
            bit_idx <= '0;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         bad_q         <= 1'b0;
         rx_parity_err <= 1'b0;
      end else begin
         rx_parity_err <= par_bad;
         if (state == IDLE) bad_q <= 1'b0;
         else if (par_bad)  bad_q <= 1'b1;
      end
   end
`else
   assign rx_parity_err = 1'b0;
`endif

   // Output word is held apart from the shift register so reception overlaps the handshake.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         rx_data       <= '0;
         rx_data_valid <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_overrun    <= 1'b0;
      end else begin
         rx_frame_err <= frame_err_set;
         rx_overrun   <= 1'b0;
         if (deliver) begin
            if (!rx_data_valid || rx_data_ready) begin
               rx_data       <= shift;
               rx_data_valid <= 1'b1;
            end else begin
               rx_overrun <= 1'b1;
            end
         end else if (rx_data_valid && rx_data_ready) begin
            rx_data_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_modify_uart_rx.sv
// Directed bench for modify_uart_rx; honours UART_RX_PARITY_EN like the RTL.
module tb_modify_uart_rx;

   localparam int W   = 8;
   localparam int CYC = 138;
`ifdef UART_RX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int LAT_MIN = (W + 1 + PAR) * CYC + CYC / 2;
   localparam int LAT_MAX = LAT_MIN + 4;

   logic         clk = 1'b0;
   logic         n_reset;
   logic         rx_pin;
   logic [W-1:0] rx_data;
   logic         rx_data_valid;
   logic         rx_data_ready;
   logic         rx_frame_err, rx_overrun, rx_parity_err;

   modify_uart_rx #(.Challenge_Bit(W), .CLK_FRE(16), .BAUD_RATE(115200)) dut (
      .clk           (clk),
      .n_reset       (n_reset),
      .rx_pin        (rx_pin),
      .rx_data       (rx_data),
      .rx_data_valid (rx_data_valid),
      .rx_data_ready (rx_data_ready),
      .rx_frame_err  (rx_frame_err),
      .rx_overrun    (rx_overrun),
      .rx_parity_err (rx_parity_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0;
   int cyc = 0, start_cyc = 0, rise_cyc = 0;
   int rises = 0, falls = 0, ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0;
   logic prev_valid = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_data_valid && !prev_valid) begin
         rises    <= rises + 1;
         rise_cyc <= cyc;
      end
      if (!rx_data_valid && prev_valid) falls <= falls + 1;
      if (rx_frame_err)  ferr_cnt <= ferr_cnt + 1;
      if (rx_overrun)    ovr_cnt  <= ovr_cnt + 1;
      if (rx_parity_err) perr_cnt <= perr_cnt + 1;
      prev_valid <= rx_data_valid;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the stop bit ends.
   task automatic send_frame(input logic [W-1:0] d, input bit bad_par, input bit stop_v);
      start_cyc = cyc;
      rx_pin = 1'b0;
      repeat (CYC) @(negedge clk);
      for (int i = 0; i < W; i++) begin
         rx_pin = d[i];
         repeat (CYC) @(negedge clk);
      end
      if (PAR != 0) begin
         rx_pin = (^d) ^ bad_par;
         repeat (CYC) @(negedge clk);
      end
      rx_pin = stop_v;
      repeat (CYC) @(negedge clk);
   endtask

   task automatic consume();
      rx_data_ready = 1'b1;
      @(negedge clk);
      rx_data_ready = 1'b0;
   endtask

   initial begin
      int lat, falls0;
      n_reset = 1'b0;
      rx_pin = 1'b1;
      rx_data_ready = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_data", rx_data, 8'h00);
      chk("rst_valid", rx_data_valid, 1'b0);
      chk("rst_ferr", rx_frame_err, 1'b0);
      chk("rst_ovr", rx_overrun, 1'b0);
      chk("rst_perr", rx_parity_err, 1'b0);
      n_reset = 1'b1;
      repeat (10) @(negedge clk);

      // Basic frame and latency window
      send_frame(8'h69, 1'b0, 1'b1);
      lat = rise_cyc - start_cyc;
      chk("f69_rises", rises, 1);
      chk("f69_data", rx_data, 8'h69);
      chk("f69_valid", rx_data_valid, 1'b1);
      chk("f69_lat_lo", lat >= LAT_MIN, 1'b1);
      chk("f69_lat_hi", lat <= LAT_MAX, 1'b1);
      consume();
      chk("f69_clear", rx_data_valid, 1'b0);

      // Short low glitch is rejected silently
      rx_pin = 1'b0;
      repeat (40) @(negedge clk);
      rx_pin = 1'b1;
      repeat (2 * CYC) @(negedge clk);
      chk("glitch_rises", rises, 1);
      chk("glitch_ferr", ferr_cnt, 0);
      chk("glitch_valid", rx_data_valid, 1'b0);

      // Bad stop bit, held-low line, then a clean frame
      send_frame(8'hA5, 1'b0, 1'b0);
      repeat (3 * CYC) @(negedge clk);
      rx_pin = 1'b1;
      repeat (2 * CYC) @(negedge clk);
      chk("ferr_cnt", ferr_cnt, 1);
      chk("ferr_rises", rises, 1);
      send_frame(8'h3C, 1'b0, 1'b1);
      chk("f3c_rises", rises, 2);
      chk("f3c_data", rx_data, 8'h3C);
      chk("f3c_ferr", ferr_cnt, 1);
      consume();

      // Overrun with ready held low
      send_frame(8'h11, 1'b0, 1'b1);
      send_frame(8'h22, 1'b0, 1'b1);
      chk("ovr_data", rx_data, 8'h11);
      chk("ovr_valid", rx_data_valid, 1'b1);
      chk("ovr_cnt", ovr_cnt, 1);
      // Ready on the completion edge: replace without overrun or valid drop
      falls0 = falls;
      fork
         send_frame(8'h22, 1'b0, 1'b1);
         begin
            repeat (LAT_MIN + 2) @(negedge clk);
            rx_data_ready = 1'b1;
            @(negedge clk);
            rx_data_ready = 1'b0;
         end
      join
      chk("swap_data", rx_data, 8'h22);
      chk("swap_ovr", ovr_cnt, 1);
      chk("swap_nofall", falls, falls0);
      chk("swap_valid", rx_data_valid, 1'b1);
      consume();
      chk("swap_clear", rx_data_valid, 1'b0);

      // Reset mid-DATA of 0xFF
      rx_pin = 1'b0;
      repeat (CYC) @(negedge clk);
      rx_pin = 1'b1;
      repeat (3 * CYC) @(negedge clk);
      n_reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("mrst_data", rx_data, 8'h00);
      chk("mrst_flags", {rx_data_valid, rx_frame_err, rx_overrun, rx_parity_err}, 4'b0000);
      n_reset = 1'b1;
      repeat (20) @(negedge clk);
      send_frame(8'h5A, 1'b0, 1'b1);
      lat = rise_cyc - start_cyc;
      chk("f5a_data", rx_data, 8'h5A);
      chk("f5a_rises", rises, 4);
      chk("f5a_lat", (lat >= LAT_MIN) && (lat <= LAT_MAX), 1'b1);
      chk("f5a_ferr", ferr_cnt, 1);
      consume();

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1);
      repeat (10) @(negedge clk);
      chk("pbad_perr", perr_cnt, 1);
      chk("pbad_rises", rises, 4);
      chk("pbad_valid", rx_data_valid, 1'b0);
      send_frame(8'h07, 1'b0, 1'b1);
      chk("pgood_data", rx_data, 8'h07);
      chk("pgood_valid", rx_data_valid, 1'b1);
      chk("pgood_perr", perr_cnt, 1);
`else
      chk("noparity_perr", perr_cnt, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
